// File: rtl/pe_lif_array.sv
`default_nettype none
// ============================================================================
// Module      : pe_lif_array
// Description : Leaky integrate-and-fire processing element holding
//               N_NEURONS membrane potentials and a signed weight table
//               indexed by pre-synaptic address. Integrates one weight per
//               neuron per cycle while accum_en is high; on spike_done it
//               sweeps the neurons one per cycle (threshold, fire, leak,
//               refractory) and emits a registered spike vector.
// Options     : PE_SAT_EN - when defined, accumulation and leak saturate to
//               the signed V_WIDTH range; otherwise they wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_lif_array #(
  parameter int N_NEURONS  = 4,
  parameter int N_INPUTS   = 16,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 12,
  parameter int THRESH     = 100,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  localparam int AW = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int RW = (REFRAC    > 0) ? $clog2(REFRAC + 1) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 accum_en,
  input  logic [AW-1:0]        pe_addr,
  input  logic                 spike_done,
  input  logic                 wr_en,
  input  logic [NW-1:0]        wr_neuron,
  input  logic [AW-1:0]        wr_addr,
  input  logic [W_WIDTH-1:0]   wr_data,
  input  logic [NW-1:0]        v_sel,
  output logic [V_WIDTH-1:0]   v_out,
  output logic                 busy,
  output logic                 spike_valid,
  output logic [N_NEURONS-1:0] spike_out
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_e;

  localparam logic signed [V_WIDTH-1:0] THRESH_V = V_WIDTH'(THRESH);
  localparam logic [RW-1:0]             REFRAC_V = RW'(REFRAC);

  state_e                      state_q, state_d;
  logic [NW-1:0]               idx_q, idx_d;
  logic signed [W_WIDTH-1:0]   w_q [N_NEURONS][N_INPUTS];
  logic signed [W_WIDTH-1:0]   w_d [N_NEURONS][N_INPUTS];
  logic signed [V_WIDTH-1:0]   v_q [N_NEURONS];
  logic signed [V_WIDTH-1:0]   v_d [N_NEURONS];
  logic [RW-1:0]               refrac_q [N_NEURONS];
  logic [RW-1:0]               refrac_d [N_NEURONS];
  logic [N_NEURONS-1:0]        spike_acc_q, spike_acc_d;
  logic [N_NEURONS-1:0]        spike_out_q, spike_out_d;
  logic                        spike_valid_q, spike_valid_d;
  logic                        busy_q, busy_d;
  logic [V_WIDTH-1:0]          v_out_q, v_out_d;

  // Reduce a V_WIDTH+1 intermediate back to V_WIDTH (saturate or wrap).
  function automatic logic signed [V_WIDTH-1:0] fit_v(input logic signed [V_WIDTH:0] x);
`ifdef PE_SAT_EN
    if (x[V_WIDTH] != x[V_WIDTH-1])
      fit_v = x[V_WIDTH] ? {1'b1, {(V_WIDTH-1){1'b0}}} : {1'b0, {(V_WIDTH-1){1'b1}}};
    else
      fit_v = x[V_WIDTH-1:0];
`else
    fit_v = x[V_WIDTH-1:0];
`endif
  endfunction

  function automatic logic signed [V_WIDTH-1:0] add_w(input logic signed [V_WIDTH-1:0] v,
                                                      input logic signed [W_WIDTH-1:0] w);
    logic signed [V_WIDTH:0] s;
    s = $signed({v[V_WIDTH-1], v}) + $signed({{(V_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w});
    add_w = fit_v(s);
  endfunction

  // Arithmetic shift floors, so negative potentials decay toward zero (-1 -> 0).
  function automatic logic signed [V_WIDTH-1:0] leak_v(input logic signed [V_WIDTH-1:0] v);
    logic signed [V_WIDTH:0] ve;
    logic signed [V_WIDTH:0] s;
    ve     = $signed({v[V_WIDTH-1], v});
    s      = ve - (ve >>> LEAK_SHIFT);
    leak_v = fit_v(s);
  endfunction

  // Next-state logic: weight writes, parallel integration, and the per-neuron sweep.
  always_comb begin
    w_d           = w_q;
    v_d           = v_q;
    refrac_d      = refrac_q;
    state_d       = state_q;
    idx_d         = idx_q;
    spike_acc_d   = spike_acc_q;
    spike_out_d   = spike_out_q;
    spike_valid_d = 1'b0;
    busy_d        = busy_q;
    v_out_d       = '0;

    for (int n = 0; n < N_NEURONS; n++) begin
      if (v_sel == NW'(n)) v_out_d = v_q[n];
      for (int a = 0; a < N_INPUTS; a++) begin
        if (wr_en && wr_neuron == NW'(n) && wr_addr == AW'(a)) w_d[n][a] = wr_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (accum_en && int'(pe_addr) < N_INPUTS) begin
          for (int n = 0; n < N_NEURONS; n++) begin
            if (refrac_q[n] == '0) v_d[n] = add_w(v_q[n], w_q[n][pe_addr]);
            else                   v_d[n] = '0;
          end
        end
        if (spike_done) begin
          state_d     = UPDATE;
          idx_d       = '0;
          busy_d      = 1'b1;
          spike_acc_d = '0;
        end
      end
      UPDATE: begin
        for (int n = 0; n < N_NEURONS; n++) begin
          if (idx_q == NW'(n)) begin
            if (refrac_q[n] != '0) begin
              refrac_d[n] = refrac_q[n] - RW'(1);
              v_d[n]      = '0;
            end else if (v_q[n] >= THRESH_V) begin
              spike_acc_d[n] = 1'b1;
              v_d[n]         = '0;
              refrac_d[n]    = REFRAC_V;
            end else begin
              v_d[n] = leak_v(v_q[n]);
            end
          end
        end
        if (idx_q == NW'(N_NEURONS - 1)) begin
          state_d       = IDLE;
          busy_d        = 1'b0;
          spike_valid_d = 1'b1;
          spike_out_d   = spike_acc_d;
        end else begin
          idx_d = idx_q + NW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear; reset also aborts any sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      w_q           <= '{default: '0};
      v_q           <= '{default: '0};
      refrac_q      <= '{default: '0};
      spike_acc_q   <= '0;
      spike_out_q   <= '0;
      spike_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      v_out_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      w_q           <= w_d;
      v_q           <= v_d;
      refrac_q      <= refrac_d;
      spike_acc_q   <= spike_acc_d;
      spike_out_q   <= spike_out_d;
      spike_valid_q <= spike_valid_d;
      busy_q        <= busy_d;
      v_out_q       <= v_out_d;
    end
  end

  assign v_out       = v_out_q;
  assign busy        = busy_q;
  assign spike_valid = spike_valid_q;
  assign spike_out   = spike_out_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_lif_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_lif_array
// Description : Directed self-checking bench for pe_lif_array (default
//               parameters); overflow expectation follows PE_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_lif_array;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        accum_en = 1'b0;
  logic [3:0]  pe_addr = '0;
  logic        spike_done = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_neuron = '0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [1:0]  v_sel = '0;
  logic [11:0] v_out;
  logic        busy;
  logic        spike_valid;
  logic [3:0]  spike_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pe_lif_array dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .accum_en   (accum_en),
    .pe_addr    (pe_addr),
    .spike_done (spike_done),
    .wr_en      (wr_en),
    .wr_neuron  (wr_neuron),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .v_sel      (v_sel),
    .v_out      (v_out),
    .busy       (busy),
    .spike_valid(spike_valid),
    .spike_out  (spike_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; accum_en = 1'b0; spike_done = 1'b0; wr_en = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic write_w(input int n, input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_neuron = n[1:0]; wr_addr = a[3:0]; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic accum(input int a, input int cnt);
    pe_addr = a[3:0]; accum_en = 1'b1;
    repeat (cnt) step();
    accum_en = 1'b0;
  endtask

  task automatic read_v(input int n, output logic [11:0] v);
    v_sel = n[1:0];
    step();
    v = v_out;
  endtask

  // Pulse spike_done; report edges until spike_valid (-1 on timeout) and busy cycles seen.
  task automatic timestep(output int lat, output logic [3:0] so, output int bc);
    spike_done = 1'b1;
    step();
    spike_done = 1'b0;
    bc  = busy ? 1 : 0;
    lat = -1;
    so  = 4'hx;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (spike_valid) begin
        lat = k; so = spike_out;
        if (busy) bc++;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    logic [11:0] v;
    do_reset();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (spike_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", spike_valid); else pass_cnt++;
    total_cnt++; if (spike_out !== 4'b0) $display("FAIL reset_spike_out: got %b want 0000", spike_out); else pass_cnt++;
    for (int n = 0; n < 4; n++) begin
      read_v(n, v);
      total_cnt++; if (v !== 12'd0) $display("FAIL reset_v%0d: got %0d want 0", n, v); else pass_cnt++;
    end
  endtask

  task automatic test_basic_fire();
    logic [11:0] v; int lat; int bc; logic [3:0] so;
    do_reset();
    write_w(0, 1, 8'd10);
    accum(1, 12);
    read_v(0, v);
    total_cnt++; if (v !== 12'd120) $display("FAIL fire_accum_v0: got %0d want 120", v); else pass_cnt++;
    timestep(lat, so, bc);
    total_cnt++; if (lat !== 4) $display("FAIL fire_latency: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (bc !== 4) $display("FAIL fire_busy_cycles: got %0d want 4", bc); else pass_cnt++;
    total_cnt++; if (so !== 4'b0001) $display("FAIL fire_spike_out: got %b want 0001", so); else pass_cnt++;
    step();
    total_cnt++; if (spike_valid !== 1'b0) $display("FAIL fire_valid_one_cycle: got %b want 0", spike_valid); else pass_cnt++;
    total_cnt++; if (spike_out !== 4'b0001) $display("FAIL fire_spike_out_hold: got %b want 0001", spike_out); else pass_cnt++;
    read_v(0, v);
    total_cnt++; if (v !== 12'd0) $display("FAIL fire_v0_cleared: got %0d want 0", v); else pass_cnt++;
  endtask

  // Continues from test_basic_fire: neuron 0 is refractory for two timesteps.
  task automatic test_refractory();
    logic [11:0] v; int lat; int bc; logic [3:0] so;
    for (int ts = 1; ts <= 3; ts++) begin
      accum(1, 12);
      read_v(0, v);
      total_cnt++;
      if (v !== ((ts == 3) ? 12'd120 : 12'd0)) $display("FAIL refrac_v0_ts%0d: got %0d want %0d", ts, v, (ts == 3) ? 120 : 0);
      else pass_cnt++;
      timestep(lat, so, bc);
      total_cnt++;
      if (lat !== 4 || so !== ((ts == 3) ? 4'b0001 : 4'b0000))
        $display("FAIL refrac_spike_ts%0d: got lat=%0d so=%b want lat=4 so=%b", ts, lat, so, (ts == 3) ? 4'b0001 : 4'b0000);
      else pass_cnt++;
    end
  endtask

  task automatic test_leak();
    logic [11:0] v; int lat; int bc; logic [3:0] so;
    do_reset();
    write_w(1, 2, 8'd8);
    write_w(2, 0, 8'hFF);   // -1
    write_w(3, 0, 8'hEC);   // -20
    accum(2, 10);
    accum(0, 1);
    read_v(1, v);
    total_cnt++; if (v !== 12'd80) $display("FAIL leak_accum_v1: got %0d want 80", v); else pass_cnt++;
    timestep(lat, so, bc);
    total_cnt++; if (lat !== 4 || so !== 4'b0000) $display("FAIL leak_spike: got lat=%0d so=%b want lat=4 so=0000", lat, so); else pass_cnt++;
    read_v(1, v);
    total_cnt++; if (v !== 12'd70) $display("FAIL leak_v1: got %0d want 70", v); else pass_cnt++;
    read_v(2, v);
    total_cnt++; if (v !== 12'd0) $display("FAIL leak_neg1_v2: got %0d want 0", $signed(v)); else pass_cnt++;
    read_v(3, v);
    total_cnt++; if (v !== 12'hFEF) $display("FAIL leak_neg20_v3: got %0d want -17", $signed(v)); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [11:0] v;
    logic [11:0] exp_v;
`ifdef PE_SAT_EN
    exp_v = 12'd2047;
`else
    exp_v = 12'd984;
`endif
    do_reset();
    write_w(2, 3, 8'd127);
    accum(3, 40);
    read_v(2, v);
    total_cnt++; if (v !== exp_v) $display("FAIL overflow_v2: got %0d want %0d", v, exp_v); else pass_cnt++;
  endtask

  task automatic test_busy_lockout();
    logic [11:0] v; int nvalid;
    do_reset();
    write_w(0, 1, 8'd10);
    accum(1, 5);
    spike_done = 1'b1;
    step();
    spike_done = 1'b0;
    nvalid = 0;
    accum_en = 1'b1; pe_addr = 4'd1; spike_done = 1'b1;
    step(); if (spike_valid) nvalid++;
    step(); if (spike_valid) nvalid++;
    accum_en = 1'b0; spike_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(); if (spike_valid) nvalid++;
    end
    total_cnt++; if (nvalid !== 1) $display("FAIL lockout_valid_count: got %0d want 1", nvalid); else pass_cnt++;
    read_v(0, v);
    total_cnt++; if (v !== 12'd44) $display("FAIL lockout_v0: got %0d want 44", v); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; int bc; logic [3:0] so;
    do_reset();
    write_w(0, 1, 8'd10);
    accum(1, 12);
    timestep(lat, so, bc);
    total_cnt++; if (lat !== 4 || so !== 4'b0001) $display("FAIL b2b_first: got lat=%0d so=%b want lat=4 so=0001", lat, so); else pass_cnt++;
    timestep(lat, so, bc);
    total_cnt++; if (lat !== 4 || so !== 4'b0000) $display("FAIL b2b_second: got lat=%0d so=%b want lat=4 so=0000", lat, so); else pass_cnt++;
  endtask

  task automatic test_midsweep_reset();
    logic [11:0] v; int lat; int bc; int nvalid; logic [3:0] so;
    do_reset();
    write_w(0, 1, 8'd10);
    accum(1, 12);
    timestep(lat, so, bc);
    total_cnt++; if (so !== 4'b0001) $display("FAIL midrst_setup: got so=%b want 0001", so); else pass_cnt++;
    write_w(1, 1, 8'd20);
    accum(1, 12);
    spike_done = 1'b1;
    step();
    spike_done = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (spike_out !== 4'b0) $display("FAIL midrst_spike_out: got %b want 0000", spike_out); else pass_cnt++;
    total_cnt++; if (v_out !== 12'd0) $display("FAIL midrst_v_out: got %0d want 0", v_out); else pass_cnt++;
    nvalid = 0;
    step(); if (spike_valid) nvalid++;
    step(); if (spike_valid) nvalid++;
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); if (spike_valid) nvalid++;
    end
    total_cnt++; if (nvalid !== 0) $display("FAIL midrst_no_valid: got %0d want 0", nvalid); else pass_cnt++;
    for (int n = 0; n < 4; n++) begin
      read_v(n, v);
      total_cnt++; if (v !== 12'd0) $display("FAIL midrst_v%0d: got %0d want 0", n, v); else pass_cnt++;
    end
    for (int a = 0; a < 16; a++) accum(a, 1);
    for (int n = 0; n < 4; n++) begin
      read_v(n, v);
      total_cnt++; if (v !== 12'd0) $display("FAIL midrst_weights_n%0d: got %0d want 0", n, v); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_fire();
    test_refractory();
    test_leak();
    test_overflow();
    test_busy_lockout();
    test_back_to_back();
    test_midsweep_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
